// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the main-memory port arbiter: bus direction codes,
// RISC-V load/store funct3 codes, FSM state encoding and memory window defaults.
package mem_port_arbiter_pkg;

  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [31:0] MEM_STARTING_ADDR   = 32'h0100_0000;
  localparam logic [31:0] MEM_DEPTH_BYTES_DEF = 32'h0010_0000;

  localparam int unsigned STREAK_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RD   = 2'b01,
    ST_WR   = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  // Unsigned loads exist only for byte and half; stores only for byte/half/word.
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    logic ok;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = ~we;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_lane_align.sv
// Byte-lane helper for the memory arbiter: checks the offset/size legality of an
// incoming request, extracts and extends sub-word loads, and merges sub-word
// store data into a word read back from memory.
module mem_lane_align
  import mem_port_arbiter_pkg::*;
(
  input  logic        is_fetch_i,
  input  logic        chk_we_i,
  input  logic [2:0]  chk_funct3_i,
  input  logic [1:0]  chk_off_i,
  output logic        legal_o,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] rword_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_data_o,
  output logic [31:0] merged_o
);

  logic [31:0] rshift_s;
  logic [31:0] wshift_s;
  logic [3:0]  byte_mask_s;

  // Offset/size/funct3 legality of the request being arbitrated this cycle.
  always_comb begin
    legal_o = 1'b0;
    if (is_fetch_i) begin
      legal_o = (chk_off_i == 2'b00);
    end else if (!f3_legal(chk_we_i, chk_funct3_i)) begin
      legal_o = 1'b0;
    end else begin
      case (chk_funct3_i[1:0])
        2'b00:   legal_o = 1'b1;
        2'b01:   legal_o = (chk_off_i[0] == 1'b0);
        2'b10:   legal_o = (chk_off_i == 2'b00);
        default: legal_o = 1'b0;
      endcase
    end
  end

  // Load path: shift the addressed lane down to bit 0, then sign/zero extend.
  always_comb begin
    rshift_s    = rword_i >> {off_i, 3'b000};
    load_data_o = rword_i;
    case (funct3_i)
      F3_B:    load_data_o = {{24{rshift_s[7]}}, rshift_s[7:0]};
      F3_BU:   load_data_o = {24'h00_0000, rshift_s[7:0]};
      F3_H:    load_data_o = {{16{rshift_s[15]}}, rshift_s[15:0]};
      F3_HU:   load_data_o = {16'h0000, rshift_s[15:0]};
      F3_W:    load_data_o = rword_i;
      default: load_data_o = rword_i;
    endcase
  end

  // Store path: move the low store bytes up to their lane and splice them in.
  always_comb begin
    wshift_s    = wdata_i << {off_i, 3'b000};
    byte_mask_s = 4'b0000;
    case (funct3_i[1:0])
      2'b00:   byte_mask_s = 4'b0001 << off_i;
      2'b01:   byte_mask_s = 4'b0011 << off_i;
      2'b10:   byte_mask_s = 4'b1111;
      default: byte_mask_s = 4'b0000;
    endcase
    merged_o = rword_i;
    for (int i = 0; i < 4; i++) begin
      merged_o[8*i +: 8] = byte_mask_s[i] ? wshift_s[8*i +: 8] : rword_i[8*i +: 8];
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port main memory between instruction fetch and the
// load/store unit. D has priority, bounded by a streak counter so a waiting
// fetch is not starved. Sub-word stores run as read-modify-write.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter logic [31:0] STARTING_ADDR   = MEM_STARTING_ADDR,
  parameter logic [31:0] MEM_DEPTH_BYTES = MEM_DEPTH_BYTES_DEF,
  parameter int unsigned MAX_D_STREAK    = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [2:0]  d_funct3,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out,
  output logic        mem_read_write
);

  state_e              state_q, state_d;
  logic                sel_d_q, sel_d_d;
  logic                we_q, we_d;
  logic [2:0]          funct3_q, funct3_d;
  logic [1:0]          off_q, off_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                if_ack_q, if_ack_d;
  logic [31:0]         if_rdata_q, if_rdata_d;
  logic                if_err_q, if_err_d;
  logic                d_ack_q, d_ack_d;
  logic [31:0]         d_rdata_q, d_rdata_d;
  logic                d_err_q, d_err_d;
  logic [31:0]         mem_address_q, mem_address_d;
  logic [31:0]         mem_data_in_q, mem_data_in_d;

  logic        streak_full_s;
  logic        grant_d_s;
  logic        grant_if_s;
  logic        is_fetch_s;
  logic [31:0] req_addr_s;
  logic [31:0] rel_addr_s;
  logic        in_range_s;
  logic        align_ok_s;
  logic        legal_s;
  logic [31:0] load_data_s;
  logic [31:0] merged_s;

  // Arbitration and legality of whichever request would be granted this cycle.
  always_comb begin
    streak_full_s = (streak_q == STREAK_W'(MAX_D_STREAK));
    grant_d_s     = d_req & ~(if_req & streak_full_s);
    grant_if_s    = if_req & ~grant_d_s;
    is_fetch_s    = ~grant_d_s;
    req_addr_s    = grant_d_s ? d_addr : if_addr;
    rel_addr_s    = req_addr_s - STARTING_ADDR;
    in_range_s    = (rel_addr_s < MEM_DEPTH_BYTES);
    legal_s       = in_range_s & align_ok_s;
  end

  mem_lane_align u_lane (
    .is_fetch_i   (is_fetch_s),
    .chk_we_i     (d_we),
    .chk_funct3_i (d_funct3),
    .chk_off_i    (req_addr_s[1:0]),
    .legal_o      (align_ok_s),
    .funct3_i     (funct3_q),
    .off_i        (off_q),
    .rword_i      (mem_data_out),
    .wdata_i      (wdata_q),
    .load_data_o  (load_data_s),
    .merged_o     (merged_s)
  );

  // Next-state and registered-output logic of the access FSM.
  always_comb begin
    state_d       = state_q;
    sel_d_d       = sel_d_q;
    we_d          = we_q;
    funct3_d      = funct3_q;
    off_d         = off_q;
    wdata_d       = wdata_q;
    streak_d      = streak_q;
    if_ack_d      = 1'b0;
    if_rdata_d    = if_rdata_q;
    if_err_d      = if_err_q;
    d_ack_d       = 1'b0;
    d_rdata_d     = d_rdata_q;
    d_err_d       = d_err_q;
    mem_address_d = mem_address_q;
    mem_data_in_d = mem_data_in_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_d_s || grant_if_s) begin
          sel_d_d  = grant_d_s;
          we_d     = grant_d_s & d_we;
          funct3_d = grant_d_s ? d_funct3 : F3_W;
          off_d    = req_addr_s[1:0];
          wdata_d  = d_wdata;
          if (grant_d_s && if_req) begin
            streak_d = streak_q + {{(STREAK_W-1){1'b0}}, 1'b1};
          end else begin
            streak_d = {STREAK_W{1'b0}};
          end
          if (!legal_s) begin
            state_d = ST_DONE;
            if (grant_d_s) begin
              d_ack_d   = 1'b1;
              d_err_d   = 1'b1;
              d_rdata_d = 32'h0000_0000;
            end else begin
              if_ack_d   = 1'b1;
              if_err_d   = 1'b1;
              if_rdata_d = 32'h0000_0000;
            end
          end else if (grant_d_s && d_we && (d_funct3 == F3_W)) begin
            state_d       = ST_WR;
            mem_address_d = {req_addr_s[31:2], 2'b00};
            mem_data_in_d = d_wdata;
          end else begin
            state_d       = ST_RD;
            mem_address_d = {req_addr_s[31:2], 2'b00};
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RD: begin
        if (we_q) begin
          state_d       = ST_WR;
          mem_data_in_d = merged_s;
        end else if (sel_d_q) begin
          state_d   = ST_DONE;
          d_ack_d   = 1'b1;
          d_err_d   = 1'b0;
          d_rdata_d = load_data_s;
        end else begin
          state_d    = ST_DONE;
          if_ack_d   = 1'b1;
          if_err_d   = 1'b0;
          if_rdata_d = mem_data_out;
        end
      end
      ST_WR: begin
        state_d   = ST_DONE;
        d_ack_d   = 1'b1;
        d_err_d   = 1'b0;
        d_rdata_d = 32'h0000_0000;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      sel_d_q       <= 1'b0;
      we_q          <= 1'b0;
      funct3_q      <= 3'b000;
      off_q         <= 2'b00;
      wdata_q       <= 32'h0000_0000;
      streak_q      <= {STREAK_W{1'b0}};
      if_ack_q      <= 1'b0;
      if_rdata_q    <= 32'h0000_0000;
      if_err_q      <= 1'b0;
      d_ack_q       <= 1'b0;
      d_rdata_q     <= 32'h0000_0000;
      d_err_q       <= 1'b0;
      mem_address_q <= STARTING_ADDR;
      mem_data_in_q <= 32'h0000_0000;
    end else begin
      state_q       <= state_d;
      sel_d_q       <= sel_d_d;
      we_q          <= we_d;
      funct3_q      <= funct3_d;
      off_q         <= off_d;
      wdata_q       <= wdata_d;
      streak_q      <= streak_d;
      if_ack_q      <= if_ack_d;
      if_rdata_q    <= if_rdata_d;
      if_err_q      <= if_err_d;
      d_ack_q       <= d_ack_d;
      d_rdata_q     <= d_rdata_d;
      d_err_q       <= d_err_d;
      mem_address_q <= mem_address_d;
      mem_data_in_q <= mem_data_in_d;
    end
  end

  // Write strobe is gated by reset so an abort during WR never commits the word.
  always_comb begin
    mem_read_write = ((state_q == ST_WR) && reset_n) ? MEM_WRITE : MEM_READ;
  end

  assign if_ack      = if_ack_q;
  assign if_rdata    = if_rdata_q;
  assign if_err      = if_err_q;
  assign d_ack       = d_ack_q;
  assign d_rdata     = d_rdata_q;
  assign d_err       = d_err_q;
  assign mem_address = mem_address_q;
  assign mem_data_in = mem_data_in_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a behavioural memory plus a
// byte-level reference model of loads, stores, legality and latency.
module tb_mem_port_arbiter;

  localparam logic [31:0] START = 32'h0100_0000;
  localparam logic [31:0] DEPTH = 32'h0010_0000;

  logic        clock;
  logic        reset_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        if_err;
  logic        d_req;
  logic        d_we;
  logic [2:0]  d_funct3;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        d_err;
  logic [31:0] mem_address;
  logic [31:0] mem_data_in;
  logic [31:0] mem_data_out;
  logic        mem_read_write;

  logic [31:0] tb_mem  [0:1023];
  logic [31:0] ref_mem [0:1023];
  int          wr_count;
  logic        pl_en;
  logic [9:0]  pl_idx;
  logic [31:0] pl_val;

  int n_cmp;
  int n_bad;

  mem_port_arbiter dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .if_req         (if_req),
    .if_addr        (if_addr),
    .if_ack         (if_ack),
    .if_rdata       (if_rdata),
    .if_err         (if_err),
    .d_req          (d_req),
    .d_we           (d_we),
    .d_funct3       (d_funct3),
    .d_addr         (d_addr),
    .d_wdata        (d_wdata),
    .d_ack          (d_ack),
    .d_rdata        (d_rdata),
    .d_err          (d_err),
    .mem_address    (mem_address),
    .mem_data_in    (mem_data_in),
    .mem_data_out   (mem_data_out),
    .mem_read_write (mem_read_write)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory window of 4 KB, aliased over the whole address space.
  assign mem_data_out = tb_mem[mem_address[11:2]];

  always @(posedge clock) begin
    if (pl_en) begin
      tb_mem[pl_idx] <= pl_val;
    end else if (mem_read_write) begin
      tb_mem[mem_address[11:2]] <= mem_data_in;
      wr_count <= wr_count + 1;
    end
  end

  task automatic preload(input logic [31:0] addr, input logic [31:0] val);
    @(negedge clock);
    pl_en  = 1'b1;
    pl_idx = addr[11:2];
    pl_val = val;
    ref_mem[addr[11:2]] = val;
    @(negedge clock);
    pl_en = 1'b0;
  endtask

  // Drives one request and checks it against the reference model.
  task automatic run_txn(input bit is_d, input bit we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input string tag, output logic [31:0] got_rdata);
    longint      a;
    bit          in_range;
    int          size;
    int          off;
    bit          legal;
    int          exp_lat;
    logic [31:0] exp_rd;
    int          exp_wr;
    logic [31:0] word;
    logic [31:0] nword;
    int          idx;
    int          start_wr;
    bit          got;
    int          lat;
    logic        got_err;
    a        = longint'(addr);
    in_range = (a >= longint'(START)) && (a < longint'(START) + longint'(DEPTH));
    off      = int'(addr[1:0]);
    idx      = int'(addr[11:2]);
    word     = ref_mem[idx];
    exp_rd   = 32'h0;
    exp_wr   = 0;
    if (!is_d) begin
      size = 4;
    end else begin
      case (f3)
        3'b000, 3'b100: size = 1;
        3'b001, 3'b101: size = 2;
        3'b010:         size = 4;
        default:        size = 0;
      endcase
      if (we && f3[2]) size = 0;
    end
    legal = in_range && (size != 0) && ((off % ((size == 0) ? 1 : size)) == 0);
    if (!legal) begin
      exp_lat = 1;
    end else if (!is_d) begin
      exp_lat = 2;
      exp_rd  = word;
    end else if (!we) begin
      exp_lat = 2;
      for (int b = 0; b < size; b++) exp_rd[8*b +: 8] = word[8*(off+b) +: 8];
      if (!f3[2] && size < 4 && exp_rd[8*size-1]) exp_rd = exp_rd | (32'hFFFF_FFFF << (8*size));
    end else begin
      nword = word;
      for (int b = 0; b < size; b++) nword[8*(off+b) +: 8] = wdata[8*b +: 8];
      exp_lat      = (size == 4) ? 2 : 3;
      exp_wr       = 1;
      ref_mem[idx] = nword;
    end

    @(negedge clock);
    if (is_d) begin
      d_req = 1'b1; d_we = we; d_funct3 = f3; d_addr = addr; d_wdata = wdata;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    start_wr  = wr_count;
    got       = 1'b0;
    lat       = 0;
    got_err   = 1'b0;
    got_rdata = 32'h0;
    for (int k = 1; k <= 8 && !got; k++) begin
      @(negedge clock);
      if (is_d ? d_ack : if_ack) begin
        got       = 1'b1;
        lat       = k;
        got_err   = is_d ? d_err : if_err;
        got_rdata = is_d ? d_rdata : if_rdata;
      end
    end
    if_req = 1'b0;
    d_req  = 1'b0;

    n_cmp++;
    if (got !== 1'b1) begin
      n_bad++; $display("FAIL %s.ack: no ack within 8 cycles, required ack", tag);
    end
    n_cmp++;
    if (lat !== exp_lat) begin
      n_bad++; $display("FAIL %s.latency: got %0d required %0d", tag, lat, exp_lat);
    end
    n_cmp++;
    if (got_err !== !legal) begin
      n_bad++; $display("FAIL %s.err: got %0b required %0b", tag, got_err, !legal);
    end
    if (legal && !we) begin
      n_cmp++;
      if (got_rdata !== exp_rd) begin
        n_bad++; $display("FAIL %s.rdata: got %08h required %08h", tag, got_rdata, exp_rd);
      end
    end
    n_cmp++;
    if ((wr_count - start_wr) !== exp_wr) begin
      n_bad++; $display("FAIL %s.writes: got %0d required %0d", tag, wr_count - start_wr, exp_wr);
    end
    n_cmp++;
    if (tb_mem[idx] !== ref_mem[idx]) begin
      n_bad++; $display("FAIL %s.memword: got %08h required %08h", tag, tb_mem[idx], ref_mem[idx]);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    for (int i = 0; i < 1024; i++) preload(START + 32'(i * 4), $urandom);
    @(negedge clock);
    n_cmp++;
    if ({if_ack, d_ack, if_err, d_err, mem_read_write} !== 5'b00000) begin
      n_bad++; $display("FAIL reset.flags: got %05b required 00000",
                        {if_ack, d_ack, if_err, d_err, mem_read_write});
    end
    n_cmp++;
    if ({if_rdata, d_rdata, mem_data_in} !== 96'h0) begin
      n_bad++; $display("FAIL reset.data: got %08h %08h %08h required zeros", if_rdata, d_rdata, mem_data_in);
    end
    n_cmp++;
    if (mem_address !== START) begin
      n_bad++; $display("FAIL reset.addr: got %08h required %08h", mem_address, START);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_fetch();
    logic [31:0] r;
    preload(START, 32'h0000_0093);
    run_txn(1'b0, 1'b0, 3'b010, START, 32'h0, "fetch", r);
    n_cmp++;
    if (r !== 32'h0000_0093) begin
      n_bad++; $display("FAIL fetch.word: got %08h required 00000093", r);
    end
  endtask

  task automatic test_store_half();
    logic [31:0] r;
    preload(START + 32'h100, 32'hAABB_CCDD);
    run_txn(1'b1, 1'b1, 3'b001, START + 32'h102, 32'h0000_1234, "sh", r);
    n_cmp++;
    if (tb_mem[64] !== 32'h1234_CCDD) begin
      n_bad++; $display("FAIL sh.merged: got %08h required 1234ccdd", tb_mem[64]);
    end
    run_txn(1'b1, 1'b1, 3'b000, START + 32'h101, 32'hFFFF_FF5A, "sb", r);
    run_txn(1'b1, 1'b1, 3'b010, START + 32'h104, 32'hCAFE_F00D, "sw", r);
  endtask

  task automatic test_sub_loads();
    logic [31:0] r;
    preload(START + 32'h10, 32'h80FF_0000);
    run_txn(1'b1, 1'b0, 3'b000, START + 32'h13, 32'h0, "lb", r);
    n_cmp++;
    if (r !== 32'hFFFF_FF80) begin
      n_bad++; $display("FAIL lb.value: got %08h required ffffff80", r);
    end
    run_txn(1'b1, 1'b0, 3'b100, START + 32'h13, 32'h0, "lbu", r);
    n_cmp++;
    if (r !== 32'h0000_0080) begin
      n_bad++; $display("FAIL lbu.value: got %08h required 00000080", r);
    end
    run_txn(1'b1, 1'b0, 3'b001, START + 32'h12, 32'h0, "lh", r);
    run_txn(1'b1, 1'b0, 3'b101, START + 32'h12, 32'h0, "lhu", r);
  endtask

  task automatic test_errors();
    logic [31:0] r;
    run_txn(1'b1, 1'b0, 3'b010, START + 32'h1, 32'h0, "err_lw_mis", r);
    run_txn(1'b1, 1'b1, 3'b001, START + 32'h3, 32'h5555, "err_sh_mis", r);
    run_txn(1'b1, 1'b0, 3'b010, START - 32'h4, 32'h0, "err_lw_low", r);
    run_txn(1'b1, 1'b0, 3'b011, START + 32'h8, 32'h0, "err_f3", r);
    run_txn(1'b1, 1'b1, 3'b010, START + DEPTH, 32'h1, "err_sw_high", r);
    run_txn(1'b0, 1'b0, 3'b010, START + 32'h2, 32'h0, "err_if_mis", r);
    run_txn(1'b1, 1'b0, 3'b010, START + DEPTH - 32'h4, 32'h0, "lw_top", r);
  endtask

  task automatic test_random();
    logic [31:0] r;
    logic [31:0] addr;
    logic [2:0]  f3;
    bit          is_d;
    bit          we;
    logic [2:0]  f3_tab [0:7];
    f3_tab[0] = 3'b000; f3_tab[1] = 3'b001; f3_tab[2] = 3'b010; f3_tab[3] = 3'b100;
    f3_tab[4] = 3'b101; f3_tab[5] = 3'b010; f3_tab[6] = 3'b011; f3_tab[7] = 3'b110;
    for (int i = 0; i < 60; i++) begin
      is_d = ($urandom_range(0, 3) != 0);
      we   = is_d && ($urandom_range(0, 1) == 1);
      f3   = we ? f3_tab[$urandom_range(0, 2)] : f3_tab[$urandom_range(0, 7)];
      addr = START + 32'($urandom_range(0, 1023) * 4) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) addr = START - 32'($urandom_range(1, 64));
      if ($urandom_range(0, 9) == 0) addr = START + DEPTH + 32'($urandom_range(0, 64));
      run_txn(is_d, we, f3, addr, $urandom, "random", r);
    end
  endtask

  task automatic test_starvation();
    int seq [$];
    logic [31:0] exp_if;
    exp_if = ref_mem[32];
    @(negedge clock);
    d_req = 1'b1; d_we = 1'b0; d_funct3 = 3'b010; d_addr = START + 32'h40;
    if_req = 1'b1; if_addr = START + 32'h80;
    for (int k = 0; k < 80 && seq.size() < 10; k++) begin
      @(negedge clock);
      if (d_ack && if_ack) begin
        n_cmp++; n_bad++; $display("FAIL starve.both_ack: got both acks required one");
      end
      if (d_ack) seq.push_back(0);
      if (if_ack) begin
        seq.push_back(1);
        n_cmp++;
        if (if_rdata !== exp_if) begin
          n_bad++; $display("FAIL starve.if_rdata: got %08h required %08h", if_rdata, exp_if);
        end
      end
      if (seq.size() >= 10) begin
        d_req = 1'b0; if_req = 1'b0;
      end
    end
    d_req = 1'b0; if_req = 1'b0;
    n_cmp++;
    if (seq.size() != 10) begin
      n_bad++; $display("FAIL starve.count: got %0d acks required 10", seq.size());
    end
    for (int i = 0; i < seq.size(); i++) begin
      n_cmp++;
      if (seq[i] != ((i % 5 == 4) ? 1 : 0)) begin
        n_bad++; $display("FAIL starve.order[%0d]: got %0d required %0d (1=IF)", i, seq[i], (i % 5 == 4) ? 1 : 0);
      end
    end
  endtask

  task automatic test_reset_during_wr();
    logic [31:0] r;
    int          w0;
    bit          spurious;
    preload(START + 32'h200, 32'h1122_3344);
    @(negedge clock);
    d_req = 1'b1; d_we = 1'b1; d_funct3 = 3'b010; d_addr = START + 32'h200; d_wdata = 32'hDEAD_BEEF;
    w0 = wr_count;
    @(negedge clock);
    n_cmp++;
    if (mem_read_write !== 1'b1) begin
      n_bad++; $display("FAIL rstwr.in_wr: got %0b required 1", mem_read_write);
    end
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (mem_read_write !== 1'b0) begin
      n_bad++; $display("FAIL rstwr.gate: got %0b required 0", mem_read_write);
    end
    @(negedge clock);
    d_req = 1'b0;
    n_cmp++;
    if ({if_ack, d_ack, if_err, d_err, mem_read_write} !== 5'b00000 ||
        {if_rdata, d_rdata, mem_data_in} !== 96'h0 || mem_address !== START) begin
      n_bad++; $display("FAIL rstwr.outputs: got ack=%0b%0b err=%0b%0b addr=%08h din=%08h required reset values",
                        if_ack, d_ack, if_err, d_err, mem_address, mem_data_in);
    end
    n_cmp++;
    if (tb_mem[128] !== 32'h1122_3344 || wr_count != w0) begin
      n_bad++; $display("FAIL rstwr.mem: got %08h writes=%0d required 11223344 writes=0", tb_mem[128], wr_count - w0);
    end
    reset_n  = 1'b1;
    spurious = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      if (d_ack || if_ack) spurious = 1'b1;
    end
    n_cmp++;
    if (spurious) begin
      n_bad++; $display("FAIL rstwr.no_ack: got ack after abort required none");
    end
    run_txn(1'b1, 1'b0, 3'b010, START + 32'h200, 32'h0, "rstwr_readback", r);
  endtask

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    wr_count = 0;
    pl_en    = 1'b0;
    pl_idx   = 10'h000;
    pl_val   = 32'h0;
    reset_n  = 1'b0;
    if_req   = 1'b0;
    if_addr  = 32'h0;
    d_req    = 1'b0;
    d_we     = 1'b0;
    d_funct3 = 3'b000;
    d_addr   = 32'h0;
    d_wdata  = 32'h0;
    test_reset();
    test_fetch();
    test_store_half();
    test_sub_loads();
    test_errors();
    test_random();
    test_starvation();
    test_reset_during_wr();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
